// File: rtl/wb_regfile.sv
// Write-back stage: result select, architectural register file with WB->ID bypass,
// and retired-instruction / register-write event counters.
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int CNTW = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RegWriteW,
    input  logic [1:0]      ResultSrcW,
    input  logic            ValidW,
    input  logic [AW-1:0]   RdW,
    input  logic [XLEN-1:0] ALUResultW,
    input  logic [XLEN-1:0] ReadDataW,
    input  logic [XLEN-1:0] PCPlus4W,
    input  logic [AW-1:0]   A1D,
    input  logic [AW-1:0]   A2D,
    output logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [CNTW-1:0] RetireCnt,
    output logic [CNTW-1:0] WriteCnt
);

    logic [XLEN-1:0] regs_r [NREG];
    logic [CNTW-1:0] retire_cnt_r;
    logic [CNTW-1:0] write_cnt_r;
    logic [XLEN-1:0] result_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            we_s;

    // Write-back source select; the reserved encoding falls back to the ALU result.
    always_comb begin
        result_s = ALUResultW;
        case (ResultSrcW)
            2'b00:   result_s = ALUResultW;
            2'b01:   result_s = ReadDataW;
            2'b10:   result_s = PCPlus4W;
            default: result_s = ALUResultW;
        endcase
    end

    assign we_s = RegWriteW & ValidW & (RdW != {AW{1'b0}}) & ~reset;

    // Read port 1: x0 wins over bypass, bypass wins over storage.
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        if (reset || (A1D == {AW{1'b0}})) begin
            rd1_s = {XLEN{1'b0}};
        end else if (we_s && (A1D == RdW)) begin
            rd1_s = result_s;
        end else begin
            rd1_s = regs_r[A1D];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2_s = {XLEN{1'b0}};
        if (reset || (A2D == {AW{1'b0}})) begin
            rd2_s = {XLEN{1'b0}};
        end else if (we_s && (A2D == RdW)) begin
            rd2_s = result_s;
        end else begin
            rd2_s = regs_r[A2D];
        end
    end

    // Register commit and event counters; counters wrap rather than saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
            retire_cnt_r <= {CNTW{1'b0}};
            write_cnt_r  <= {CNTW{1'b0}};
        end else begin
            if (we_s) begin
                regs_r[RdW] <= result_s;
                write_cnt_r <= write_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
            if (ValidW) begin
                retire_cnt_r <= retire_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign ResultW   = result_s;
    assign RD1D      = rd1_s;
    assign RD2D      = rd2_s;
    assign RetireCnt = retire_cnt_r;
    assign WriteCnt  = write_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile: bypass, source select, x0,
// bubbles, asynchronous reset and counter wrap (on a narrow-counter instance).
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic        ValidW;
    logic [4:0]  RdW;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] ResultW, RD1D, RD2D, RetireCnt, WriteCnt;
    logic [31:0] ResultW_n, RD1D_n, RD2D_n;
    logic [3:0]  RetireCnt_n, WriteCnt_n;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .A1D(A1D), .A2D(A2D), .ResultW(ResultW),
        .RD1D(RD1D), .RD2D(RD2D), .RetireCnt(RetireCnt), .WriteCnt(WriteCnt)
    );

    // Narrow-counter copy sharing all inputs, used to reach the wrap point quickly.
    wb_regfile #(.CNTW(4)) dut_n (
        .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidW(ValidW), .RdW(RdW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .A1D(A1D), .A2D(A2D), .ResultW(ResultW_n),
        .RD1D(RD1D_n), .RD2D(RD2D_n), .RetireCnt(RetireCnt_n), .WriteCnt(WriteCnt_n)
    );

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e_res;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_ret;
        logic [31:0] e_wr;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic valid,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2);
        RegWriteW = rw; ResultSrcW = src; ValidW = valid; RdW = rd;
        ALUResultW = alu; ReadDataW = rdata; PCPlus4W = pc4; A1D = a1; A2D = a2;
    endtask

    initial begin
        // rw src valid rd alu rdata pc4 a1 a2 | ResultW RD1D RD2D RetireCnt WriteCnt (before the edge)
        vecs[0]  = '{1'b1, 2'b00, 1'b1, 5'd5,  32'h1234_5678, 32'h0, 32'h0, 5'd5,  5'd0,
                     32'h1234_5678, 32'h1234_5678, 32'h0, 32'd0, 32'd0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 5'd5,  32'h0, 32'h0, 32'h0, 5'd0,  5'd5,
                     32'h0, 32'h0, 32'h1234_5678, 32'd1, 32'd1};
        vecs[2]  = '{1'b1, 2'b01, 1'b1, 5'd7,  32'h0, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd5,
                     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 32'd1, 32'd1};
        vecs[3]  = '{1'b1, 2'b10, 1'b1, 5'd7,  32'h0, 32'hDEAD_BEEF, 32'h0000_0104, 5'd7, 5'd7,
                     32'h104, 32'h104, 32'h104, 32'd2, 32'd2};
        vecs[4]  = '{1'b0, 2'b11, 1'b1, 5'd7,  32'hA5, 32'h1, 32'h2, 5'd7, 5'd0,
                     32'hA5, 32'h104, 32'h0, 32'd3, 32'd3};
        vecs[5]  = '{1'b1, 2'b00, 1'b1, 5'd0,  32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 5'd0,
                     32'hFFFF_FFFF, 32'h0, 32'h0, 32'd4, 32'd3};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 5'd3,  32'h99, 32'h0, 32'h0, 5'd3, 5'd0,
                     32'h99, 32'h0, 32'h0, 32'd5, 32'd3};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 5'd3, 5'd0,
                     32'h0, 32'h0, 32'h0, 32'd5, 32'd3};
        vecs[8]  = '{1'b1, 2'b00, 1'b1, 5'd9,  32'h55, 32'h0, 32'h0, 5'd9, 5'd3,
                     32'h55, 32'h55, 32'h0, 32'd5, 32'd3};
        vecs[9]  = '{1'b1, 2'b00, 1'b1, 5'd10, 32'h66, 32'h0, 32'h0, 5'd9, 5'd10,
                     32'h66, 32'h55, 32'h66, 32'd6, 32'd4};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 5'd0,  32'h0, 32'h0, 32'h0, 5'd10, 5'd9,
                     32'h0, 32'h66, 32'h55, 32'd7, 32'd5};

        reset = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Post-reset: every index reads 0 on both ports.
        for (int i = 0; i < 32; i++) begin
            A1D = 5'(i);
            A2D = 5'(31 - i);
            #1;
            check("reset_rd1", RD1D, 32'h0);
            check("reset_rd2", RD2D, 32'h0);
        end
        check("reset_retire", RetireCnt, 32'd0);
        check("reset_write", WriteCnt, 32'd0);
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            drive(vecs[v].rw, vecs[v].src, vecs[v].valid, vecs[v].rd, vecs[v].alu,
                  vecs[v].rdata, vecs[v].pc4, vecs[v].a1, vecs[v].a2);
            #1;
            check($sformatf("v%0d_result", v), ResultW, vecs[v].e_res);
            check($sformatf("v%0d_rd1", v), RD1D, vecs[v].e_rd1);
            check($sformatf("v%0d_rd2", v), RD2D, vecs[v].e_rd2);
            check($sformatf("v%0d_retire", v), RetireCnt, vecs[v].e_ret);
            check($sformatf("v%0d_write", v), WriteCnt, vecs[v].e_wr);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle while a write to x11 is pending.
        drive(1'b1, 2'b00, 1'b1, 5'd11, 32'h77, 32'h0, 32'h0, 5'd11, 5'd9);
        #1;
        check("pre_rst_bypass", RD1D, 32'h77);
        check("pre_rst_x9", RD2D, 32'h55);
        #1;
        reset = 1'b1;
        #1;
        check("rst_rd1", RD1D, 32'h0);
        check("rst_rd2", RD2D, 32'h0);
        check("rst_result", ResultW, 32'h77);
        check("rst_retire", RetireCnt, 32'd0);
        check("rst_write", WriteCnt, 32'd0);
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd10);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_x9", RD1D, 32'h0);
        check("post_rst_x10", RD2D, 32'h0);
        A1D = 5'd11;
        #1;
        check("post_rst_x11", RD1D, 32'h0);
        check("post_rst_retire", RetireCnt, 32'd0);
        check("post_rst_write", WriteCnt, 32'd0);
        @(negedge clk);

        // Counter wrap on the 4-bit instance: 15 retires reach all-ones, one more wraps.
        drive(1'b0, 2'b00, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        repeat (15) @(negedge clk);
        check("wrap_pre_n", {28'h0, RetireCnt_n}, 32'h0000_000F);
        check("wrap_pre_wide", RetireCnt, 32'd15);
        @(negedge clk);
        check("wrap_n", {28'h0, RetireCnt_n}, 32'h0);
        check("wrap_wide", RetireCnt, 32'd16);
        check("wrap_write_n", {28'h0, WriteCnt_n}, 32'h0);
        ValidW = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
